// File: rtl/ripemd160_pkg.sv
// rtl/ripemd160_pkg.sv - shared constants, FSM encoding and helpers for the RIPEMD-160 block feeder
package ripemd160_pkg;

    // Padding marker byte 0x80 placed right after the 32 message bytes.
    localparam logic [31:0] RIPEMD160_PAD_WORD = 32'h00000080;
    // Message length in bits (256), low word of the 64-bit length field.
    localparam logic [31:0] RIPEMD160_LEN_256  = 32'h00000100;

    // Clock edges from the edge sampling core_start=1 to the capture edge.
    localparam int CORE_LAT_DEFAULT  = 81;
    // Extra cycles tolerated past CORE_LAT before declaring a core timeout.
    localparam int TO_MARGIN_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } feeder_state_e;

    // Reverse the byte order of a 32-bit word.
    function automatic logic [31:0] byteswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_block_fmt.sv
// rtl/ripemd160_block_fmt.sv - combinational SHA-256 digest to padded RIPEMD-160 block formatter
module ripemd160_block_fmt
    import ripemd160_pkg::*;
(
    input  logic [255:0] digest_i,
    output logic [511:0] block_o
);

    // Digest bytes are big-endian on the input; RIPEMD-160 reads little-endian
    // words, so each 32-bit digest chunk is byte-reversed into its word slot.
    always_comb begin
        block_o = '0;
        for (int i = 0; i < 8; i++) begin
            block_o[32*i +: 32] = byteswap32(digest_i[255-32*i -: 32]);
        end
        block_o[32*8  +: 32] = RIPEMD160_PAD_WORD;
        block_o[32*14 +: 32] = RIPEMD160_LEN_256;
    end

endmodule

// File: rtl/ripemd160_block_feeder.sv
// rtl/ripemd160_block_feeder.sv - issues one padded block to the RIPEMD-160 core and returns the digest
module ripemd160_block_feeder
    import ripemd160_pkg::*;
#(
    parameter int CORE_LAT  = CORE_LAT_DEFAULT,
    parameter int TO_MARGIN = TO_MARGIN_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_digest,
    output logic         core_start,
    output logic [511:0] core_block,
    input  logic         core_valid,
    input  logic [159:0] core_ans,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] out_hash,
    output logic         busy,
    output logic         err
);

    localparam int CW = (CORE_LAT > 2) ? $clog2(CORE_LAT) : 1;
    localparam int MW = $clog2(TO_MARGIN + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(CORE_LAT - 1);
    localparam logic [MW-1:0] MARGIN_MAX = MW'(TO_MARGIN);

    feeder_state_e  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  margin_q, margin_d;
    logic [511:0]   block_q, block_d;
    logic [159:0]   hash_q, hash_d;
    logic           err_q, err_d;
    logic [511:0]   fmt_block;
    logic [159:0]   ans_swapped;

    ripemd160_block_fmt u_fmt (
        .digest_i (in_digest),
        .block_o  (fmt_block)
    );

    // Canonical digest order: each state word h_j is emitted little-endian.
    always_comb begin
        ans_swapped = '0;
        for (int j = 0; j < 5; j++) begin
            ans_swapped[159-32*j -: 32] = byteswap32(core_ans[159-32*j -: 32]);
        end
    end

    // Next-state logic; core_valid is level-checked only once the latency
    // counter has expired because the core holds it high between jobs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        margin_d = margin_q;
        block_d  = block_q;
        hash_d   = hash_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    block_d = fmt_block;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d    = CNT_LOAD;
                margin_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (core_valid) begin
                    hash_d  = ans_swapped;
                    state_d = ST_OUT;
                end else if (margin_q == MARGIN_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    margin_d = margin_q + MW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            margin_q <= '0;
            block_q  <= '0;
            hash_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            margin_q <= margin_d;
            block_q  <= block_d;
            hash_q   <= hash_d;
            err_q    <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign core_start = (state_q == ST_ISSUE);
    assign out_valid  = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);
    assign core_block = block_q;
    assign out_hash   = hash_q;
    assign err        = err_q;

endmodule
